multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main sequencer for the multicycle MIPS datapath. A Moore state machine walks each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable and mux select, and decodes the 3-bit `alu_control` word consumed by the shared ALU. One ALU serves PC increment, branch-target computation, address generation and R-type execution, so this block decides, cycle by cycle, which operation it performs.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; forces FETCH.
- `opcode`  in  6  instruction[31:26], valid from IR after FETCH.
- `funct`  in  6  instruction[5:0].
- `zero`  in  1  ALU zero flag, same cycle.
- `pc_en`  out  1  PC register write enable.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_write`  out  1  data memory write.
- `ir_write`  out  1  instruction register load.
- `reg_dst`  out  1  write register select: 0 = rt, 1 = rd.
- `mem_to_reg`  out  1  write data select: 0 = ALUOut, 1 = memory data.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alu_src_b`  out  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_control`  out  3  ALU operation: 010 = add, 110 = sub, 000 = and, 001 = or, 111 = slt.
- `illegal`  out  1  one-cycle flag raised in DECODE when the opcode is unsupported.
- `state`  out  4  current state encoding, for debug and verification.

## Operation
- State encodings are fixed: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Supported opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010 (bne 000101 only under the macro).
- Transitions:
  - FETCH → DECODE, unconditionally.
  - DECODE → MEMADR for lw/sw; EXECUTE for R-type; BRANCH for beq (and bne under the macro); ADDIEX for addi; JUMP for j.
  - DECODE → FETCH for any other opcode, with `illegal` = 1 for that cycle.
  - MEMADR → MEMRD for lw, MEMWR for sw.
  - MEMRD → MEMWB.
  - EXECUTE → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all → FETCH.
  - Unused encodings 12–15 → FETCH.
- Per-state outputs. Every output not listed is 0; `alu_op` is internal.
  - FETCH: `ir_write` = 1, `alu_src_b` = 01, `alu_op` = 00, `pc_write` = 1.
  - DECODE: `alu_src_b` = 11, `alu_op` = 00.
  - MEMADR: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00.
  - MEMRD: `i_or_d` = 1.
  - MEMWB: `reg_write` = 1, `mem_to_reg` = 1.
  - MEMWR: `i_or_d` = 1, `mem_write` = 1.
  - EXECUTE: `alu_src_a` = 1, `alu_op` = 10.
  - ALUWB: `reg_dst` = 1, `reg_write` = 1.
  - BRANCH: `alu_src_a` = 1, `alu_op` = 01, `pc_src` = 01, `branch` = 1.
  - ADDIEX: `alu_src_a` = 1, `alu_src_b` = 10, `alu_op` = 00.
  - ADDIWB: `reg_write` = 1.
  - JUMP: `pc_src` = 10, `pc_write` = 1.
- `pc_en` = `pc_write` | (`branch` & `zero`). Under the macro, bne adds (`branch_ne` & ~`zero`).
- ALU decode, purely combinational:
  - `alu_op` 00 → 010 (add).
  - `alu_op` 01 → 110 (sub).
  - `alu_op` 10 decodes `funct`: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111, any other → 010.

## Timing
- State is the only register. It updates on the rising edge of `clk`.
- All outputs are combinational from `state`, except `pc_en` (also `zero`), `alu_control` (also `funct`) and `illegal` (also `opcode`).
- Reset is asynchronous. Asserting `reset` takes the state to FETCH immediately, including mid-instruction; the partially executed instruction is abandoned with no further writes.
- Outputs during reset equal the FETCH outputs: `ir_write` = 1, `pc_en` = 1, `alu_src_b` = 01, `alu_control` = 010, all else 0. The datapath holds its own registers in reset, so these have no effect.
- The first FETCH edge after `reset` deasserts is a normal fetch.
- Cycles per instruction, counting FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, bne 3, illegal opcode 2.
- `opcode` and `funct` must be stable from the FETCH edge until the next FETCH, which holds because IR is written only in FETCH.

## Configuration
- Macro: `MULTICYCLE_BNE_EN`.
- Defined:
  - Opcode 000101 goes DECODE → BRANCH.
  - BRANCH drives internal `branch_ne` instead of `branch` for this opcode.
  - The PC is taken when `zero` = 0.
- Undefined: 000101 is illegal; it raises `illegal` and returns to FETCH after 2 cycles.

## Test plan
- Reset asserted mid-MEMRD of a lw → `state` = 0 before the next clock edge; `mem_write` = `reg_write` = 0; `alu_control` = 010.
- lw (opcode 100011) → states 0, 1, 2, 3, 4, 0; `reg_write` & `mem_to_reg` = 1 only in state 4; 5 cycles total.
- R-type with `funct` 101010, then 100100, then 100101, then 100010 → in EXECUTE, `alu_control` = 111, 000, 001, 110 respectively; `reg_dst` = 1 in ALUWB.
- beq with `zero` = 1 → `pc_en` = 1, `pc_src` = 01, `alu_control` = 110 in BRANCH; with `zero` = 0 → `pc_en` = 0.
- sw, then j → sw: `mem_write` = 1 only in state 5, 4 cycles; j: `pc_src` = 10, `pc_en` = 1 in state 11, 3 cycles.
- Opcode 000101 → with the macro, `zero` = 0 gives `pc_en` = 1 in BRANCH; without it, `illegal` = 1 in DECODE, then `state` = 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main sequencer for the multicycle MIPS datapath: Moore FSM plus shared-ALU decode.
// Optional bne support is enabled by defining MULTICYCLE_BNE_EN.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [2:0] alu_control,
   output logic       illegal,
   output logic [3:0] state
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OP_W    = 6;

   localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
   localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
   localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
   localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
   localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
   localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_BNE_EN
   localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_e;

   state_e     state_q, state_d;
   logic [1:0] alu_op;
   logic       pc_write;
   logic       branch;
   logic       branch_ne;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_FETCH;
      else       state_q <= state_d;
   end

   assign state = STATE_W'(state_q);

   // Next-state selection; illegal flags an unsupported opcode while in DECODE.
   always_comb begin
      state_d = S_FETCH;
      illegal = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef MULTICYCLE_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         default:   state_d = S_FETCH;
      endcase
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      i_or_d     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_src     = 2'b00;
      alu_op     = 2'b00;
      pc_write   = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
         end
         S_DECODE:  alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD:   i_or_d = 1'b1;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 2'b01;
`ifdef MULTICYCLE_BNE_EN
            branch_ne = (opcode == OP_BNE);
            branch    = (opcode != OP_BNE);
`else
            branch    = 1'b1;
`endif
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB:  reg_write = 1'b1;
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign pc_en = pc_write | (branch & zero) | (branch_ne & ~zero);

   // Shared-ALU operation: add for PC/address math, sub for compare, funct for R-type.
   always_comb begin
      alu_control = 3'b010;
      case (alu_op)
         2'b01: alu_control = 3'b110;
         2'b10: begin
            case (funct)
               6'b100000: alu_control = 3'b010;
               6'b100010: alu_control = 3'b110;
               6'b100100: alu_control = 3'b000;
               6'b100101: alu_control = 3'b001;
               6'b101010: alu_control = 3'b111;
               default:   alu_control = 3'b010;
            endcase
         end
         default: alu_control = 3'b010;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level reference model.
// Honors MULTICYCLE_BNE_EN the same way as the design.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic       illegal;
   logic [3:0] state;

   int checks   = 0;
   int failures = 0;

`ifdef MULTICYCLE_BNE_EN
   localparam bit BNE_ON = 1'b1;
`else
   localparam bit BNE_ON = 1'b0;
`endif

   multicycle_control dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .pc_en(pc_en), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
      .alu_control(alu_control), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   // Instruction class: 0 lw, 1 sw, 2 R, 3 beq, 4 addi, 5 j, 6 bne, 7 illegal
   function automatic int op_class(input logic [5:0] op);
      case (op)
         6'b100011: return 0;
         6'b101011: return 1;
         6'b000000: return 2;
         6'b000100: return 3;
         6'b001000: return 4;
         6'b000010: return 5;
         6'b000101: return BNE_ON ? 6 : 7;
         default:   return 7;
      endcase
   endfunction

   function automatic int n_cycles(input logic [5:0] op);
      int lens[8] = '{5, 4, 4, 3, 4, 3, 3, 2};
      return lens[op_class(op)];
   endfunction

   // State visited at step idx of an instruction (step 0 is FETCH).
   function automatic int exp_state(input logic [5:0] op, input int idx);
      int c = op_class(op);
      int s2[8] = '{2, 2, 6, 8, 9, 11, 8, 0};
      int s3[8] = '{3, 5, 7, 0, 10, 0, 0, 0};
      if (idx == 0) return 0;
      if (idx == 1) return 1;
      if (idx == 2) return s2[c];
      if (idx == 3) return s3[c];
      return 4;
   endfunction

   function automatic logic [2:0] funct_op(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Packed {pc_en,i_or_d,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,pc_src,alu_control,illegal}
   function automatic logic [15:0] exp_out(input int s, input logic [5:0] op,
                                           input logic [5:0] fn, input logic z);
      logic pe = 0, iod = 0, mw = 0, irw = 0, rd = 0, m2r = 0, rw = 0, sa = 0, ill = 0;
      logic [1:0] sb = 2'b00, ps = 2'b00;
      logic [2:0] ac = 3'b010;
      case (s)
         0:  begin irw = 1; sb = 2'b01; pe = 1; end
         1:  begin sb = 2'b11; ill = (op_class(op) == 7); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  iod = 1;
         4:  begin rw = 1; m2r = 1; end
         5:  begin iod = 1; mw = 1; end
         6:  begin sa = 1; ac = funct_op(fn); end
         7:  begin rd = 1; rw = 1; end
         8:  begin sa = 1; ps = 2'b01; ac = 3'b110; pe = (op_class(op) == 6) ? ~z : z; end
         9:  begin sa = 1; sb = 2'b10; end
         10: rw = 1;
         11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {pe, iod, mw, irw, rd, m2r, rw, sa, sb, ps, ac, ill};
   endfunction

   function automatic logic [15:0] dut_out();
      return {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
              alu_src_b, pc_src, alu_control, illegal};
   endfunction

   // Walk one instruction from FETCH; zmode 0/1 forces zero, 2 randomizes it each cycle.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode);
      int n = n_cycles(op);
      for (int i = 0; i < n; i++) begin
         int es = exp_state(op, i);
         logic [15:0] eo;
         opcode = op;
         funct  = fn;
         zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
         #1;
         eo = exp_out(es, op, fn, zero);
         checks++;
         if (state !== 4'(es)) begin
            failures++;
            $display("FAIL state op=%b step=%0d got=%0d exp=%0d", op, i, state, es);
         end
         checks++;
         if (dut_out() !== eo) begin
            failures++;
            $display("FAIL outputs op=%b fn=%b state=%0d zero=%b got=%b exp=%b",
                     op, fn, es, zero, dut_out(), eo);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (state !== 4'd0) begin
         failures++;
         $display("FAIL cycle_count op=%b got_state=%0d exp=0 after %0d cycles", op, state, n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         checks++;
         if (state !== 4'd0 || dut_out() !== exp_out(0, opcode, funct, zero)) begin
            failures++;
            $display("FAIL reset_state state=%0d out=%b exp_out=%b", state, dut_out(),
                     exp_out(0, opcode, funct, zero));
         end
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_lw();
      run_instr(6'b100011, 6'($urandom), 2);
   endtask

   task automatic test_rtype();
      logic [5:0] fns[4] = '{6'b101010, 6'b100100, 6'b100101, 6'b100010};
      foreach (fns[k]) run_instr(6'b000000, fns[k], 2);
      run_instr(6'b000000, 6'b100000, 2);
      run_instr(6'b000000, 6'b111111, 2);
   endtask

   task automatic test_beq();
      run_instr(6'b000100, 6'($urandom), 1);
      run_instr(6'b000100, 6'($urandom), 0);
   endtask

   task automatic test_sw_j();
      run_instr(6'b101011, 6'($urandom), 2);
      run_instr(6'b000010, 6'($urandom), 2);
   endtask

   task automatic test_bne();
      run_instr(6'b000101, 6'($urandom), 0);
      run_instr(6'b000101, 6'($urandom), 1);
   endtask

   task automatic test_random();
      logic [5:0] ops[7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                             6'b001000, 6'b000010, 6'b000101};
      for (int k = 0; k < 60; k++) begin
         logic [5:0] op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 6)];
         logic [5:0] fn = ($urandom_range(0, 1) == 0) ? 6'($urandom)
                          : {3'b100, 3'($urandom_range(0, 7))};
         run_instr(op, fn, 2);
      end
   endtask

   task automatic test_reset_mid();
      opcode = 6'b100011; funct = 6'b0; zero = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (state !== 4'd3) begin
         failures++;
         $display("FAIL reach_memrd got=%0d exp=3", state);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (state !== 4'd0 || mem_write !== 1'b0 || reg_write !== 1'b0 ||
          alu_control !== 3'b010 || ir_write !== 1'b1 || pc_en !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid state=%0d mw=%b rw=%b ac=%b irw=%b pe=%b exp 0/0/0/010/1/1",
                  state, mem_write, reg_write, alu_control, ir_write, pc_en);
      end
      @(negedge clk);
      reset = 1'b0;
      run_instr(6'b001000, 6'($urandom), 2);
   endtask

   initial begin
      test_reset();
      test_lw();
      test_rtype();
      test_beq();
      test_sw_j();
      test_bne();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
